// File: rtl/washer_arbiter.sv
// Round-robin arbiter that lends one washingMachine to N_REQ requesters, drives its
// start/pause/rst and aborts stalled jobs. Define WASHER_ARB_PRIO0_EN to make req[0] urgent.
module washer_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64,
  parameter int GUARD   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic                     door_open,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] job_id,
  output logic                     busy,
  output logic                     job_done,
  output logic                     timeout_err,
  output logic                     wm_start,
  output logic                     wm_pause,
  output logic                     wm_rst,
  input  logic [2:0]               wm_stage,
  input  logic                     wm_done
);

  localparam int IDW = $clog2(N_REQ);
  localparam int WDW = $clog2(TIMEOUT);
  localparam int GDW = $clog2(GUARD + 1);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    PAUSED,
    RELEASE,
    GUARD_WAIT
  } state_t;

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   winner;
  logic [IDW-1:0]   idx;
  logic             found;
  logic             rr_upd;
  logic [WDW-1:0]   wd_cnt;
  logic [GDW-1:0]   gd_cnt;
  logic [2:0]       prev_stage;
  logic             stage_chg;

  assign stage_chg = (wm_stage != prev_stage);

  // Winner search starts just past the last owner and wraps around.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    winner = rr_ptr;
    found  = 1'b0;
    rr_upd = 1'b1;
    idx    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = IDW'((int'(rr_ptr) + i) % N_REQ);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
`ifdef WASHER_ARB_PRIO0_EN
    if (req[0]) begin
      winner = '0;
      found  = 1'b1;
      rr_upd = 1'b0;
    end
`endif
  end

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= IDW'(N_REQ - 1);
      grant       <= '0;
      job_id      <= '0;
      busy        <= 1'b0;
      job_done    <= 1'b0;
      timeout_err <= 1'b0;
      wm_start    <= 1'b0;
      wm_pause    <= 1'b0;
      wm_rst      <= 1'b0;
      wd_cnt      <= '0;
      gd_cnt      <= '0;
      prev_stage  <= '0;
    end else begin
      job_done    <= 1'b0;
      timeout_err <= 1'b0;
      wm_rst      <= 1'b0;
      prev_stage  <= wm_stage;
      unique case (state)
        IDLE: begin
          if (found) begin
            state    <= RUN;
            grant    <= N_REQ'(1) << winner;
            job_id   <= winner;
            busy     <= 1'b1;
            wm_start <= 1'b1;
            wd_cnt   <= '0;
            if (rr_upd) rr_ptr <= winner;
          end
        end
        RUN: begin
          wd_cnt <= stage_chg ? '0 : wd_cnt + 1'b1;
          if (wm_done || (!stage_chg && wd_cnt == WDW'(TIMEOUT - 1))) begin
            job_done    <= wm_done;
            timeout_err <= !wm_done;
            state       <= RELEASE;
            grant       <= '0;
            wm_start    <= 1'b0;
            wm_pause    <= 1'b0;
            wm_rst      <= 1'b1;
          end else if (door_open) begin
            state    <= PAUSED;
            wm_pause <= 1'b1;
          end
        end
        PAUSED: begin
          // Watchdog is frozen and wm_done ignored until the door closes.
          if (!door_open) begin
            state    <= RUN;
            wm_pause <= 1'b0;
          end
        end
        RELEASE: begin
          state  <= GUARD_WAIT;
          busy   <= 1'b0;
          gd_cnt <= '0;
        end
        GUARD_WAIT: begin
          if (gd_cnt == GDW'(GUARD - 1)) state <= IDLE;
          else gd_cnt <= gd_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
